// File: rtl/mod_n_serial_tx_pkg.sv
// Shared types and helpers for the mod-N serial transmitter and its checker
// models.
//   tx_state_e : transmitter FSM state (IDLE / SHIFT)
//   mod_step   : reference remainder update (2*rem + b) mod m, for models
//                and scoreboards
package mod_n_serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  function automatic int unsigned mod_step(int unsigned rem, logic b, int unsigned m);
    return (2 * rem + {31'd0, b}) % m;
  endfunction

endpackage

// File: rtl/mod_n_serial_tx_if.sv
// Bus bundle for mod_n_serial_tx.
//   master : word source / stream consumer (drives in_valid, in_data)
//   slave  : the transmitter (drives in_ready and the serial stream outputs)
// Signals: in_valid/in_data/in_ready word handshake; data_out, bit_valid,
// word_last serial stream; rem_out/div_flag running stream remainder mod MOD.
interface mod_n_serial_tx_if #(
  parameter int WIDTH = 8,
  parameter int MOD   = 5
);
  localparam int REM_W = $clog2(MOD);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             data_out;
  logic             bit_valid;
  logic             word_last;
  logic [REM_W-1:0] rem_out;
  logic             div_flag;

  modport master (
    output in_valid, in_data,
    input  in_ready, data_out, bit_valid, word_last, rem_out, div_flag
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, data_out, bit_valid, word_last, rem_out, div_flag
  );
endinterface

// File: rtl/mod_n_serial_tx_rem_step.sv
// mod_n_rem_step: registered running remainder of a bit stream modulo MOD.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (rem=0, div=1)
//   step_en    : a new stream bit is being registered this edge
//   clr        : treat the previous remainder as 0 (restart at this bit)
//   b          : the stream bit
//   rem_q      : remainder including the most recently registered bit
//   div_q      : rem_q == 0, registered alongside rem_q
module mod_n_rem_step #(
  parameter int MOD = 5,
  localparam int REM_W = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             clr,
  input  logic             b,
  output logic [REM_W-1:0] rem_q,
  output logic             div_q
);

  localparam logic [REM_W:0] MOD_W = (REM_W+1)'(MOD);

  logic [REM_W-1:0] base;
  logic [REM_W:0]   sum;
  logic [REM_W:0]   red;
  logic [REM_W-1:0] rem_d;
  logic             div_d;

  // 2*rem+b is at most 2*MOD-1, so one conditional subtract finishes the
  // reduction and the extra top bit holds the intermediate.
  always_comb begin
    base  = clr ? '0 : rem_q;
    sum   = {base, b};
    red   = (sum >= MOD_W) ? (sum - MOD_W) : sum;
    rem_d = rem_q;
    div_d = div_q;
    if (step_en) begin
      rem_d = red[REM_W-1:0];
      div_d = (red == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= 1'b1;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/mod_n_serial_tx.sv
// mod_n_serial_tx: parallel-to-serial MSB-first transmitter with a running
// stream remainder modulo MOD.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mod_n_serial_tx_if.slave (word handshake in, serial stream
//                plus rem_out/div_flag out)
// Build option: define MOD_N_SERIAL_TX_WORD_CLR_EN to restart the remainder
// at every word's MSB (per-word divisibility); otherwise it runs across
// words and only reset clears it.
module mod_n_serial_tx
  import mod_n_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mod_n_serial_tx_if.slave  bus
);

  localparam int REM_W = $clog2(MOD);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic             last;
  logic             ready;
  logic             load;
  logic             step_en;
  logic             clr;
  logic [REM_W-1:0] rem;
  logic             div;

  always_comb begin
    last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    ready   = (state_q == IDLE) || last;
    load    = bus.in_valid && ready;
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = bus.in_data;
        end
      end
      SHIFT: begin
        if (!last) begin
          cnt_d   = cnt_q + 1'b1;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else if (load) begin
          // back-to-back word: no bubble after the LSB
          cnt_d   = '0;
          shreg_d = bus.in_data;
        end else begin
          // clearing the shifter keeps data_out at 0 while idle
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
    // the remainder advances exactly when a valid bit lands on data_out
    step_en = (state_d == SHIFT);
`ifdef MOD_N_SERIAL_TX_WORD_CLR_EN
    clr     = load;
`else
    clr     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  mod_n_rem_step #(.MOD(MOD)) u_rem (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (step_en),
    .clr     (clr),
    .b       (shreg_d[WIDTH-1]),
    .rem_q   (rem),
    .div_q   (div)
  );

  assign bus.in_ready  = ready;
  assign bus.data_out  = shreg_q[WIDTH-1];
  assign bus.bit_valid = (state_q == SHIFT);
  assign bus.word_last = last;
  assign bus.rem_out   = rem;
  assign bus.div_flag  = div;

endmodule
